// File: rtl/ibex_data_bus_arbiter.sv
// Two-host round-robin arbiter for the Ibex req/gnt/rvalid data bus.
// Requests are held on the device bus until granted; granted host ids queue so responses route in order.
module ibex_data_bus_arbiter #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   h0_req_i,
    input  logic                   h0_we_i,
    input  logic [DataWidth/8-1:0] h0_be_i,
    input  logic [AddrWidth-1:0]   h0_addr_i,
    input  logic [DataWidth-1:0]   h0_wdata_i,
    output logic                   h0_gnt_o,
    output logic                   h0_rvalid_o,
    output logic [DataWidth-1:0]   h0_rdata_o,
    output logic                   h0_err_o,

    input  logic                   h1_req_i,
    input  logic                   h1_we_i,
    input  logic [DataWidth/8-1:0] h1_be_i,
    input  logic [AddrWidth-1:0]   h1_addr_i,
    input  logic [DataWidth-1:0]   h1_wdata_i,
    output logic                   h1_gnt_o,
    output logic                   h1_rvalid_o,
    output logic [DataWidth-1:0]   h1_rdata_o,
    output logic                   h1_err_o,

    output logic                   dev_req_o,
    output logic                   dev_we_o,
    output logic [DataWidth/8-1:0] dev_be_o,
    output logic [AddrWidth-1:0]   dev_addr_o,
    output logic [DataWidth-1:0]   dev_wdata_o,
    input  logic                   dev_gnt_i,
    input  logic                   dev_rvalid_i,
    input  logic [DataWidth-1:0]   dev_rdata_i,
    input  logic                   dev_err_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_e;

    state_e                state, state_next;
    logic                  owner, owner_next;
    logic                  rr_ptr, rr_ptr_next;
    logic [CntW-1:0]       count, count_next;
    logic [PtrW-1:0]       rd_ptr, wr_ptr;
    logic [MaxOutstanding-1:0] fifo_id;

    logic sel;
    logic req_raw;
    logic any_req;
    logic full;
    logic grant;
    logic push;
    logic pop;
    logic head;
    logic underflow;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    assign any_req = h0_req_i | h1_req_i;
    assign full    = (count == CntMax);

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        sel         = 1'b0;
        req_raw     = 1'b0;
        unique case (state)
            ST_ARB: begin
                sel     = (h0_req_i && h1_req_i) ? rr_ptr : h1_req_i;
                req_raw = any_req && !full;
                if (req_raw && !dev_gnt_i) begin
                    state_next = ST_LOCKED;
                    owner_next = sel;
                end
            end
            ST_LOCKED: begin
                // Lock is only entered below the limit, so the held request ignores full.
                sel     = owner;
                req_raw = 1'b1;
                if (dev_gnt_i) begin
                    state_next = ST_ARB;
                end
            end
            default: state_next = ST_ARB;
        endcase
        dev_req_o = req_raw && rst_ni;
        grant     = dev_req_o && dev_gnt_i;
        if (grant) begin
            rr_ptr_next = ~sel;
        end
    end

    assign dev_we_o    = sel ? h1_we_i    : h0_we_i;
    assign dev_be_o    = sel ? h1_be_i    : h0_be_i;
    assign dev_addr_o  = sel ? h1_addr_i  : h0_addr_i;
    assign dev_wdata_o = sel ? h1_wdata_i : h0_wdata_i;

    assign h0_gnt_o = grant && !sel;
    assign h1_gnt_o = grant && sel;

    assign push      = grant;
    assign pop       = dev_rvalid_i && (count != '0);
    assign underflow = dev_rvalid_i && (count == '0);
    assign head      = fifo_id[rd_ptr];

    assign h0_rvalid_o = pop && !head;
    assign h1_rvalid_o = pop && head;
    assign h0_err_o    = pop && !head && dev_err_i;
    assign h1_err_o    = pop && head && dev_err_i;
    assign h0_rdata_o  = dev_rdata_i;
    assign h1_rdata_o  = dev_rdata_i;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CntW'(1);
        end else if (pop && !push) begin
            count_next = count - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_ARB;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_ptr_next;
            count  <= count_next;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Host-id storage carries no control meaning until count covers it, so it is not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_id[wr_ptr] <= sel;
        end
    end

    a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dev_req_o && !dev_gnt_i |=> dev_req_o && $stable(dev_we_o) && $stable(dev_be_o)
                                    && $stable(dev_addr_o) && $stable(dev_wdata_o));
    a_gnt0_req: assert property (@(posedge clk_i) disable iff (!rst_ni) h0_gnt_o |-> h0_req_i);
    a_gnt1_req: assert property (@(posedge clk_i) disable iff (!rst_ni) h1_gnt_o |-> h1_req_i);
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CntMax);
    a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) !(h0_gnt_o && h1_gnt_o));
    a_one_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) !(h0_rvalid_o && h1_rvalid_o));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow)
        else $warning("device response with no outstanding transaction dropped");

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Scoreboard bench for ibex_data_bus_arbiter: stimulus queues expected grants/responses, a monitor pops them.
module tb_ibex_data_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        h0_req, h0_we, h1_req, h1_we;
    logic [3:0]  h0_be, h1_be;
    logic [31:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
    logic        h0_gnt, h0_rvalid, h0_err, h1_gnt, h1_rvalid, h1_err;
    logic [31:0] h0_rdata, h1_rdata;
    logic        dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
    logic [3:0]  dev_be;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;

    ibex_data_bus_arbiter #(
        .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr),
        .h0_wdata_i(h0_wdata), .h0_gnt_o(h0_gnt), .h0_rvalid_o(h0_rvalid),
        .h0_rdata_o(h0_rdata), .h0_err_o(h0_err),
        .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
        .h1_wdata_i(h1_wdata), .h1_gnt_o(h1_gnt), .h1_rvalid_o(h1_rvalid),
        .h1_rdata_o(h1_rdata), .h1_err_o(h1_err),
        .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_addr_o(dev_addr),
        .dev_wdata_o(dev_wdata), .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
        .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
    );

    typedef struct {
        logic        host;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        logic        host;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic exp_g(input logic h, input logic we, input logic [31:0] a, input logic [31:0] wd);
        gnt_t g;
        g.host = h; g.we = we; g.addr = a; g.wdata = wd;
        exp_gnt.push_back(g);
    endtask

    task automatic exp_r(input logic h, input logic [31:0] d, input logic e);
        rsp_t r;
        r.host = h; r.rdata = d; r.err = e;
        exp_rsp.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant/response the DUT presents must match the head of its queue.
    always @(negedge clk) begin : monitor
        gnt_t g;
        rsp_t r;
        if (rst_n === 1'b1) begin
            if (h0_gnt || h1_gnt) begin
                if (exp_gnt.size() == 0) begin
                    check1("unexpected_gnt", 1'b1, 1'b0);
                end else begin
                    g = exp_gnt.pop_front();
                    check1("gnt_host", h1_gnt, g.host);
                    check1("gnt_we", dev_we, g.we);
                    check32("gnt_addr", dev_addr, g.addr);
                    check32("gnt_wdata", dev_wdata, g.wdata);
                end
            end
            if (h0_rvalid || h1_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    check1("unexpected_rvalid", 1'b1, 1'b0);
                end else begin
                    r = exp_rsp.pop_front();
                    check1("rsp_host", h1_rvalid, r.host);
                    check32("rsp_rdata", r.host ? h1_rdata : h0_rdata, r.rdata);
                    check1("rsp_err", r.host ? h1_err : h0_err, r.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        h0_req = 0; h0_we = 0; h0_be = 4'hF; h0_addr = 0; h0_wdata = 0;
        h1_req = 0; h1_we = 0; h1_be = 4'hF; h1_addr = 0; h1_wdata = 0;
        dev_gnt = 0; dev_rvalid = 0; dev_rdata = 0; dev_err = 0;

        #2;
        check32("reset_outputs", 32'({dev_req, h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, h0_err, h1_err}), 32'h0);
        check32("reset_count", 32'(dut.count), 32'h0);
        #10 rst_n = 1'b1;
        step();

        // Single h0 read granted immediately, response two cycles later.
        h0_req = 1; h0_we = 0; h0_addr = 32'h100; h0_wdata = 0; dev_gnt = 1;
        exp_g(0, 0, 32'h100, 0);
        exp_r(0, 32'hDEADBEEF, 0);
        #2 check1("t1_h0_gnt", h0_gnt, 1'b1);
        step(); h0_req = 0; dev_gnt = 0;
        step();
        step(); dev_rvalid = 1; dev_rdata = 32'hDEADBEEF;
        #2 check1("t1_h0_rvalid", h0_rvalid, 1'b1);
        check1("t1_h1_rvalid", h1_rvalid, 1'b0);
        step(); dev_rvalid = 0;
        check32("t1_count", 32'(dut.count), 32'h0);

        // Both hosts request back to back; pointer favours h1 after the h0 grant.
        h0_req = 1; h0_we = 0; h0_addr = 32'h10; h0_wdata = 0;
        h1_req = 1; h1_we = 1; h1_addr = 32'h20; h1_wdata = 32'h1111;
        dev_gnt = 1;
        exp_g(1, 1, 32'h20, 32'h1111); exp_g(0, 0, 32'h10, 0);
        exp_g(1, 1, 32'h20, 32'h1111); exp_g(0, 0, 32'h10, 0);
        exp_r(1, 32'hA000_0001, 0); exp_r(0, 32'hA000_0002, 0);
        exp_r(1, 32'hA000_0003, 1); exp_r(0, 32'hA000_0004, 0);
        #2 check1("t2_first_h1", h1_gnt, 1'b1);
        step(); dev_rvalid = 1; dev_rdata = 32'hA000_0001;
        #2 check32("t2_count_push_pop", 32'(dut.count), 32'h1);
        step(); dev_rdata = 32'hA000_0002;
        step(); dev_rdata = 32'hA000_0003; dev_err = 1;
        step(); h0_req = 0; h1_req = 0; dev_gnt = 0; dev_rdata = 32'hA000_0004; dev_err = 0;
        step(); dev_rvalid = 0;
        check32("t2_count", 32'(dut.count), 32'h0);

        // h1 write held for three ungranted cycles while h0 joins.
        h1_req = 1; h1_we = 1; h1_be = 4'h3; h1_addr = 32'h200; h1_wdata = 32'h55AA;
        h0_we = 0; h0_addr = 32'h300; h0_wdata = 0;
        exp_g(1, 1, 32'h200, 32'h55AA); exp_g(0, 0, 32'h300, 0);
        exp_r(1, 32'h1234, 0); exp_r(0, 32'h3000, 0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check1("t3_hold_req", dev_req, 1'b1);
            check32("t3_hold_addr", dev_addr, 32'h200);
            check32("t3_hold_wdata", dev_wdata, 32'h55AA);
            check32("t3_hold_be", 32'(dev_be), 32'h3);
            check1("t3_no_gnt", h0_gnt | h1_gnt, 1'b0);
            step(); h0_req = 1;
        end
        dev_gnt = 1;
        #2 check1("t3_h1_gnt", h1_gnt, 1'b1);
        step(); h1_req = 0;
        #2 check1("t3_h0_next", h0_gnt, 1'b1);

        // Two outstanding: third request blocked until a pop is registered.
        step(); h0_addr = 32'h304;
        exp_g(0, 0, 32'h304, 0);
        exp_r(0, 32'h3040, 0);
        #2 check1("t4_full_blocks", dev_req, 1'b0);
        check1("t4_full_no_gnt", h0_gnt, 1'b0);
        step(); dev_rvalid = 1; dev_rdata = 32'h1234;
        #2 check1("t4_pop_same_cycle", dev_req, 1'b0);
        step(); dev_rvalid = 0;
        #2 check1("t4_resume_req", dev_req, 1'b1);
        check1("t4_resume_gnt", h0_gnt, 1'b1);
        step(); h0_req = 0; dev_gnt = 0; dev_rvalid = 1; dev_rdata = 32'h3000;
        step(); dev_rdata = 32'h3040;
        step(); dev_rvalid = 0;
        check32("t4_count", 32'(dut.count), 32'h0);

        // Response with nothing outstanding is dropped.
        dev_rvalid = 1; dev_rdata = 32'h0BAD;
        #2 check1("t5_drop_h0", h0_rvalid, 1'b0);
        check1("t5_drop_h1", h1_rvalid, 1'b0);
        check1("t5_flagged", dut.underflow, 1'b1);
        step(); dev_rvalid = 0;
        check32("t5_count", 32'(dut.count), 32'h0);

        // Reset while locked on h1 with one outstanding; h0 wins afterwards.
        h0_req = 1; h0_addr = 32'h400; dev_gnt = 1;
        exp_g(0, 0, 32'h400, 0);
        step(); h0_req = 0; h1_req = 1; h1_we = 1; h1_be = 4'hF; h1_addr = 32'h600; h1_wdata = 32'h66; dev_gnt = 0;
        step();
        #2 check1("t6_locked_req", dev_req, 1'b1);
        check32("t6_locked_addr", dev_addr, 32'h600);
        check32("t6_outstanding", 32'(dut.count), 32'h1);
        rst_n = 0;
        #1 check1("t6_reset_req", dev_req, 1'b0);
        check32("t6_reset_count", 32'(dut.count), 32'h0);
        h1_req = 0;
        #10 rst_n = 1;
        step();
        h0_req = 1; h0_addr = 32'h500; h1_req = 1; dev_gnt = 1;
        exp_g(0, 0, 32'h500, 0); exp_g(1, 1, 32'h600, 32'h66);
        exp_r(0, 32'hC0, 0); exp_r(1, 32'hC1, 0);
        #2 check1("t6_h0_priority", h0_gnt, 1'b1);
        step(); h0_req = 0;
        step(); h1_req = 0; dev_gnt = 0; dev_rvalid = 1; dev_rdata = 32'hC0;
        step(); dev_rdata = 32'hC1;
        step(); dev_rvalid = 0;
        check32("t6_count", 32'(dut.count), 32'h0);

        step(); step();
        check32("gnt_queue_empty", exp_gnt.size(), 32'h0);
        check32("rsp_queue_empty", exp_rsp.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
